// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - control and status bundle between decode/execute and the fetch stage
interface pc_fetch_unit_if #(
    parameter int PC_WIDTH = 16
);
    logic                start;
    logic                stall;
    logic                branch_taken;
    logic [7:0]          branch_offset;
    logic                jump;
    logic [PC_WIDTH-1:0] jump_target;
    logic                halt;
    logic [PC_WIDTH-1:0] pc_out;
    logic                pc_valid;
    logic                redirected;
    logic                halted;
    logic                fault;
    logic [15:0]         instr_count;

    modport master (
        output start, stall, branch_taken, branch_offset, jump, jump_target, halt,
        input  pc_out, pc_valid, redirected, halted, fault, instr_count
    );

    modport slave (
        input  start, stall, branch_taken, branch_offset, jump, jump_target, halt,
        output pc_out, pc_valid, redirected, halted, fault, instr_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC sequencer with IDLE/RUN/HALT control feeding the instruction ROM
// Optional PC range check against PROG_END is compiled in with `define PC_BOUNDS_CHECK_EN.
module pc_fetch_unit #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PROG_END = PC_WIDTH'(51)
) (
    input  logic           clk,
    input  logic           reset,
    pc_fetch_unit_if.slave bus
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc_target;
    logic [PC_WIDTH-1:0] pc_next;
    logic [15:0]         count_next;
    logic                redirect_next;
    logic                fault_next;
    logic                out_of_range;

    always_comb begin
        pc_target = bus.pc_out + PC_ONE;
        if (bus.jump) begin
            pc_target = bus.jump_target;
        end else if (bus.branch_taken) begin
            pc_target = bus.pc_out + {{(PC_WIDTH-8){bus.branch_offset[7]}}, bus.branch_offset};
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    assign out_of_range = (pc_target > PROG_END);
`else
    assign out_of_range = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = bus.pc_out;
        count_next    = bus.instr_count;
        redirect_next = 1'b0;
        fault_next    = bus.fault;
        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_next = RUN;
                    pc_next    = RESET_PC;
                    count_next = '0;
                    fault_next = 1'b0;
                end
            end
            RUN: begin
                // A stalled cycle freezes everything; redirect inputs are re-presented later
                if (!bus.stall) begin
                    if (bus.instr_count != 16'hFFFF) begin
                        count_next = bus.instr_count + 16'd1;
                    end
                    if (bus.halt) begin
                        state_next = HALT;
                    end else if (out_of_range) begin
                        state_next = HALT;
                        fault_next = 1'b1;
                    end else begin
                        pc_next       = pc_target;
                        redirect_next = bus.jump | bus.branch_taken;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pc_out      <= RESET_PC;
            bus.pc_valid    <= 1'b0;
            bus.redirected  <= 1'b0;
            bus.halted      <= 1'b0;
            bus.fault       <= 1'b0;
            bus.instr_count <= '0;
        end else begin
            bus.pc_out      <= pc_next;
            bus.pc_valid    <= (state_next == RUN);
            bus.redirected  <= redirect_next;
            bus.halted      <= (state_next == HALT);
            bus.fault       <= fault_next;
            bus.instr_count <= count_next;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with a cycle-level reference model
module tb_pc_fetch_unit;
    localparam int PROG_END = 51;

    logic clk;
    logic reset;

    pc_fetch_unit_if #(.PC_WIDTH(16)) bus ();

    pc_fetch_unit #(
        .PC_WIDTH(16),
        .RESET_PC(16'h0000),
        .PROG_END(16'd51)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        valid;
        logic        redir;
        logic        halted;
        logic        fault;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: mode 0 idle, 1 run, 2 halt
    int m_mode;
    int m_pc;
    int m_cnt;
    int m_redir;
    int m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_cnt   = 0;
        m_redir = 0;
        m_fault = 0;
    endtask

    task automatic model_step(input bit st, input bit sl, input bit br, input logic [7:0] off,
                              input bit jp, input logic [15:0] jt, input bit hl);
        int target;
        m_redir = 0;
        if (m_mode != 1) begin
            if (st) begin
                m_mode  = 1;
                m_pc    = 0;
                m_cnt   = 0;
                m_fault = 0;
            end
        end else if (!sl) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (hl) begin
                m_mode = 2;
            end else begin
                if (jp) target = int'(jt);
                else if (br) target = m_pc + ((off >= 8'd128) ? int'(off) - 256 : int'(off));
                else target = m_pc + 1;
                target = (target + 65536) % 65536;
`ifdef PC_BOUNDS_CHECK_EN
                if (target > PROG_END) begin
                    m_mode  = 2;
                    m_fault = 1;
                end else begin
                    m_pc    = target;
                    m_redir = (jp || br) ? 1 : 0;
                end
`else
                m_pc    = target;
                m_redir = (jp || br) ? 1 : 0;
`endif
            end
        end
    endtask

    task automatic cycle(input bit st, input bit sl, input bit br, input logic [7:0] off,
                         input bit jp, input logic [15:0] jt, input bit hl);
        exp_t e;
        @(negedge clk);
        bus.start         = st;
        bus.stall         = sl;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        bus.jump          = jp;
        bus.jump_target   = jt;
        bus.halt          = hl;
        model_step(st, sl, br, off, jp, jt, hl);
        e.pc     = 16'(m_pc);
        e.valid  = (m_mode == 1);
        e.redir  = (m_redir != 0);
        e.halted = (m_mode == 2);
        e.fault  = (m_fault != 0);
        e.cnt    = 16'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic nop();
        cycle(0, 0, 0, 8'h00, 0, 16'h0000, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected record per driven cycle, compared just after the edge it describes
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pc_out",      32'(bus.pc_out),      32'(e.pc));
                chk("sb_pc_valid",    32'(bus.pc_valid),    32'(e.valid));
                chk("sb_redirected",  32'(bus.redirected),  32'(e.redir));
                chk("sb_halted",      32'(bus.halted),      32'(e.halted));
                chk("sb_fault",       32'(bus.fault),       32'(e.fault));
                chk("sb_instr_count", 32'(bus.instr_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = 0;
        bus.jump = 0; bus.jump_target = 0; bus.halt = 0;
        model_reset();
        #12;
        chk("rst_pc_out",      32'(bus.pc_out), 0);
        chk("rst_pc_valid",    32'(bus.pc_valid), 0);
        chk("rst_redirected",  32'(bus.redirected), 0);
        chk("rst_halted",      32'(bus.halted), 0);
        chk("rst_fault",       32'(bus.fault), 0);
        chk("rst_instr_count", 32'(bus.instr_count), 0);
        @(negedge clk);
        reset = 1'b0;

        nop();
        cycle(1, 0, 0, 8'h00, 0, 16'h0000, 0);
        repeat (5) nop();
        settle();
        chk("run5_pc_out", 32'(bus.pc_out), 5);
        chk("run5_count",  32'(bus.instr_count), 5);
        chk("run5_valid",  32'(bus.pc_valid), 1);

        cycle(0, 0, 0, 8'h00, 1, 16'd20, 0);
        cycle(0, 0, 1, 8'hF6, 0, 16'h0000, 0);
        settle();
        chk("branch_back_pc", 32'(bus.pc_out), 10);
        chk("branch_redir",   32'(bus.redirected), 1);
        nop();
        settle();
        chk("redir_one_cycle", 32'(bus.redirected), 0);

        cycle(0, 0, 0, 8'h00, 1, 16'd20, 0);
        cycle(0, 0, 1, 8'hF6, 1, 16'd40, 0);
        settle();
        chk("jump_wins_pc", 32'(bus.pc_out), 40);

        cycle(0, 0, 0, 8'h00, 1, 16'd7, 0);
        repeat (3) cycle(0, 1, 0, 8'h00, 1, 16'd33, 0);
        settle();
        chk("stall_pc",    32'(bus.pc_out), 7);
        chk("stall_count", 32'(bus.instr_count), 11);
        chk("stall_redir", 32'(bus.redirected), 0);
        cycle(0, 0, 0, 8'h00, 1, 16'd33, 0);
        settle();
        chk("post_stall_pc", 32'(bus.pc_out), 33);

        cycle(0, 0, 0, 8'h00, 1, 16'd31, 0);
        cycle(0, 0, 0, 8'h00, 0, 16'h0000, 1);
        settle();
        chk("halt_halted", 32'(bus.halted), 1);
        chk("halt_valid",  32'(bus.pc_valid), 0);
        chk("halt_pc",     32'(bus.pc_out), 31);
        cycle(0, 0, 1, 8'h05, 1, 16'd9, 0);
        cycle(0, 0, 0, 8'h00, 0, 16'h0000, 0);
        cycle(1, 0, 0, 8'h00, 0, 16'h0000, 0);
        settle();
        chk("restart_pc",    32'(bus.pc_out), 0);
        chk("restart_count", 32'(bus.instr_count), 0);

        cycle(0, 0, 1, 8'hFF, 0, 16'h0000, 0);
        settle();
`ifdef PC_BOUNDS_CHECK_EN
        chk("neg_branch_fault", 32'(bus.fault), 1);
        cycle(1, 0, 0, 8'h00, 0, 16'h0000, 0);
        cycle(0, 0, 0, 8'h00, 1, 16'd51, 0);
        nop();
        settle();
        chk("bound_fault",  32'(bus.fault), 1);
        chk("bound_halted", 32'(bus.halted), 1);
        chk("bound_pc",     32'(bus.pc_out), 51);
        cycle(1, 0, 0, 8'h00, 0, 16'h0000, 0);
`else
        chk("wrap_neg_pc", 32'(bus.pc_out), 32'hFFFF);
        nop();
        settle();
        chk("wrap_inc_pc", 32'(bus.pc_out), 0);
`endif
        cycle(1, 0, 0, 8'h00, 0, 16'h0000, 0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), 8'($urandom()),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 60)),
                  ($urandom_range(0, 19) == 0));
        end

        cycle(1, 0, 0, 8'h00, 0, 16'h0000, 0);
        cycle(0, 0, 0, 8'h00, 1, 16'd12, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_pc",    32'(bus.pc_out), 0);
        chk("async_rst_valid", 32'(bus.pc_valid), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        nop();
        cycle(1, 0, 0, 8'h00, 0, 16'h0000, 0);
        nop();

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
